reaction_trial_fsm: RTL and testbench

- Trial controller for the reaction timer; sits directly downstream of the free-running 12-bit pseudo-random generator and consumes its random_num word.
- On start, samples random_num to form a random stimulus delay, then lights the stimulus LED.
- Measures the player's reaction time in milliseconds and flags false starts and timeouts.
- Results feed the display/score stage.

---
 rtl/reaction_pkg.sv | 22 ++
 rtl/reaction_trial_fsm_ms_tick_gen.sv | 31 +++
 rtl/reaction_trial_fsm.sv | 142 ++++++++++++++
 tb/tb_reaction_trial_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction timer trial path.
// The display stage reuses the default constants below.
package reaction_pkg;

  localparam int RAND_W  = 12;
  localparam int DELAY_W = 13;
  localparam int REACT_W = 14;

  localparam int DEF_CLKS_PER_MS  = 50000;
  localparam int DEF_MIN_DELAY_MS = 1000;
  localparam int DEF_MAX_REACT_MS = 9999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DELAY,
    ST_STIM,
    ST_DONE,
    ST_FALSE_START,
    ST_TIMEOUT
  } trial_state_e;

endpackage

// File: rtl/reaction_trial_fsm_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLKS_PER_MS clocks,
// restartable from zero through a synchronous clear.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W =
    (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_trial_fsm.sv
// Reaction trial controller: random delay, stimulus LED,
// millisecond reaction timing with false-start and timeout flags.
module reaction_trial_fsm
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS  = DEF_CLKS_PER_MS,
  parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int MAX_REACT_MS = DEF_MAX_REACT_MS
) (
  input  logic               CLK_50MHZ,
  input  logic               RESET,
  input  logic [RAND_W-1:0]  random_num,
  input  logic               start,
  input  logic               button,
  output logic               led_stim,
  output logic               busy,
  output logic               result_valid,
  output logic               false_start,
  output logic               timeout,
  output logic [REACT_W-1:0] reaction_ms
);

  localparam logic [DELAY_W-1:0] MIN_D =
    DELAY_W'(MIN_DELAY_MS);
  localparam logic [REACT_W-1:0] MAX_R =
    REACT_W'(MAX_REACT_MS);

  trial_state_e       state_q;
  trial_state_e       state_d;
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] delay_d;
  logic [REACT_W-1:0] react_q;
  logic [REACT_W-1:0] react_d;
  logic [REACT_W-1:0] react_inc;
  logic [REACT_W-1:0] reaction_d;
  logic               led_d;
  logic               busy_d;
  logic               rv_d;
  logic               fs_d;
  logic               to_d;
  logic               tick;
  logic               tick_clr;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .clk  (CLK_50MHZ),
    .rst  (RESET),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign react_inc = react_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    react_d    = react_q;
    reaction_d = reaction_ms;
    led_d      = led_stim;
    rv_d       = result_valid;
    fs_d       = false_start;
    to_d       = timeout;
    tick_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FALSE_START, ST_TIMEOUT: begin
        if (start) begin
          state_d    = ST_WAIT_DELAY;
          delay_d    = MIN_D + {1'b0, random_num};
          tick_clr   = 1'b1;
          rv_d       = 1'b0;
          fs_d       = 1'b0;
          to_d       = 1'b0;
          reaction_d = '0;
        end
      end
      ST_WAIT_DELAY: begin
        // An early press beats the final delay tick.
        if (button) begin
          state_d = ST_FALSE_START;
          fs_d    = 1'b1;
        end else if (tick) begin
          delay_d = delay_q - 1'b1;
          if (delay_q == DELAY_W'(1)) begin
            state_d  = ST_STIM;
            led_d    = 1'b1;
            react_d  = '0;
            tick_clr = 1'b1;
          end
        end
      end
      ST_STIM: begin
        if (button) begin
          state_d    = ST_DONE;
          reaction_d = react_q;
          led_d      = 1'b0;
          rv_d       = 1'b1;
        end else if (tick) begin
          react_d = react_inc;
          if (react_inc >= MAX_R) begin
            state_d    = ST_TIMEOUT;
            reaction_d = MAX_R;
            led_d      = 1'b0;
            to_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_WAIT_DELAY) ||
             (state_d == ST_STIM);
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      delay_q      <= '0;
      react_q      <= '0;
      reaction_ms  <= '0;
      led_stim     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      react_q      <= react_d;
      reaction_ms  <= reaction_d;
      led_stim     <= led_d;
      busy         <= busy_d;
      result_valid <= rv_d;
      false_start  <= fs_d;
      timeout      <= to_d;
    end
  end

endmodule

// File: tb/tb_reaction_trial_fsm.sv
// Directed bench for reaction_trial_fsm with a 4-clock ms tick,
// 2 ms delay floor and a 20 ms reaction ceiling.
module tb_reaction_trial_fsm;

  logic        CLK_50MHZ = 1'b0;
  logic        RESET = 1'b1;
  logic [11:0] random_num = '0;
  logic        start = 1'b0;
  logic        button = 1'b0;
  logic        led_stim;
  logic        busy;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [13:0] reaction_ms;

  int tests = 0;
  int fails = 0;

  reaction_trial_fsm #(
    .CLKS_PER_MS  (4),
    .MIN_DELAY_MS (2),
    .MAX_REACT_MS (20)
  ) dut (
    .CLK_50MHZ    (CLK_50MHZ),
    .RESET        (RESET),
    .random_num   (random_num),
    .start        (start),
    .button       (button),
    .led_stim     (led_stim),
    .busy         (busy),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .reaction_ms  (reaction_ms)
  );

  always #5 CLK_50MHZ = ~CLK_50MHZ;

  task automatic step();
    @(posedge CLK_50MHZ);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic begin_trial(input logic [11:0] r);
    random_num = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_led(input int n0, output int n);
    n = n0;
    while (led_stim !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".led"}, led_stim, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".rv"}, result_valid, 0);
    check({tag, ".fs"}, false_start, 0);
    check({tag, ".to"}, timeout, 0);
    check({tag, ".ms"}, reaction_ms, 0);
  endtask

  task automatic trial1(input string tag);
    int n;
    begin_trial(12'd3);
    check({tag, ".busy0"}, busy, 1);
    check({tag, ".led0"}, led_stim, 0);
    wait_led(0, n);
    check({tag, ".led_cyc"}, n, 20);
    step_n(12);
    button = 1'b1;
    step();
    button = 1'b0;
    check({tag, ".rv"}, result_valid, 1);
    check({tag, ".ms"}, reaction_ms, 3);
    check({tag, ".led_off"}, led_stim, 0);
    check({tag, ".busy_off"}, busy, 0);
  endtask

  initial begin
    int n;
    int m;

    step_n(2);
    check_idle("reset");
    RESET = 1'b0;
    step();

    trial1("s1");

    begin_trial(12'd0);
    wait_led(0, n);
    check("s2.led_cyc", n, 8);
    m = 0;
    while (timeout !== 1'b1 && m < 200) begin
      step();
      m++;
    end
    check("s2.to_cyc", m, 80);
    check("s2.ms", reaction_ms, 20);
    check("s2.led", led_stim, 0);
    check("s2.rv", result_valid, 0);
    check("s2.busy", busy, 0);

    begin_trial(12'd3);
    check("s3a.to_clr", timeout, 0);
    step_n(4);
    button = 1'b1;
    step();
    button = 1'b0;
    check("s3a.fs", false_start, 1);
    check("s3a.busy", busy, 0);
    check("s3a.ms", reaction_ms, 0);
    step_n(30);
    check("s3a.led", led_stim, 0);
    check("s3a.fs_hold", false_start, 1);

    begin_trial(12'd3);
    check("s3b.fs_clr", false_start, 0);
    step_n(19);
    check("s3b.led19", led_stim, 0);
    check("s3b.busy19", busy, 1);
    button = 1'b1;
    step();
    button = 1'b0;
    check("s3b.fs", false_start, 1);
    check("s3b.led20", led_stim, 0);
    check("s3b.ms", reaction_ms, 0);

    begin_trial(12'd3);
    wait_led(0, n);
    check("s4.led_cyc", n, 20);
    step_n(5);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_idle("s4.rst");
    trial1("s4");

    random_num = 12'd3;
    start = 1'b1;
    button = 1'b1;
    step();
    start = 1'b0;
    button = 1'b0;
    check("s5.rv", result_valid, 0);
    check("s5.busy", busy, 1);
    check("s5.fs", false_start, 0);
    step_n(2);
    random_num = 12'hfff;
    start = 1'b1;
    step();
    start = 1'b0;
    random_num = 12'd0;
    check("s5.busy_ign", busy, 1);
    wait_led(3, n);
    check("s5.led_cyc", n, 20);
    button = 1'b1;
    step();
    button = 1'b0;
    check("s5.rv_done", result_valid, 1);
    check("s5.ms0", reaction_ms, 0);

    button = 1'b1;
    step_n(3);
    check("s6.rv_hold", result_valid, 1);
    begin_trial(12'd3);
    check("s6.busy", busy, 1);
    check("s6.fs0", false_start, 0);
    step();
    check("s6.fs", false_start, 1);
    check("s6.busy_off", busy, 0);
    button = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
